// File: rtl/fetch_stage.sv
// Instruction-fetch stage with PC, single-outstanding imem handshake and IF/ID register.
// Optional perf counters (perf_fetched, perf_bubbles) built when FETCH_PERF_CNT_EN is defined.
module fetch_stage #(
  parameter int               ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ifid_valid,
  output logic [31:0]       ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [5:0]        opcode,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_bubbles,
`endif
  output logic [5:0]        funct
);

  // state  | meaning
  // S_REQ  | request outstanding at r_pc
  // S_HOLD | returned word buffered during stall, no request
  // S_DROP | stale request at r_drop_addr outstanding after redirect
  typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DROP = 2'd2} state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_drop_addr;
  logic [31:0]       r_buf;
  logic              r_ifid_valid;
  logic [31:0]       r_ifid_instr;
  logic [ADDR_W-1:0] r_ifid_pc4;

  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_redir_pc;

  assign w_pc4      = r_pc + ADDR_W'(4);
  assign w_redir_pc = {redirect_pc[ADDR_W-1:2], 2'b00};

  // Request is suppressed while reset is asserted regardless of the old state.
  assign imem_req  = reset_n && (r_state != S_HOLD);
  assign imem_addr = (r_state == S_DROP) ? r_drop_addr : r_pc;

  assign ifid_valid = r_ifid_valid;
  assign ifid_instr = r_ifid_instr;
  assign ifid_pc4   = r_ifid_pc4;
  assign opcode     = r_ifid_instr[31:26];
  assign funct      = r_ifid_instr[5:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_REQ;
      r_pc         <= RESET_PC;
      r_drop_addr  <= RESET_PC;
      r_buf        <= '0;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
    end else if (redirect_valid) begin
      r_pc         <= w_redir_pc;
      r_ifid_valid <= 1'b0;
      r_ifid_instr <= '0;
      r_ifid_pc4   <= '0;
      case (r_state)
        S_REQ: begin
          if (!imem_valid) begin
            r_drop_addr <= r_pc;
            r_state     <= S_DROP;
          end
        end
        S_HOLD: r_state <= S_REQ;
        // A stale response landing in the same cycle still retires the drop.
        S_DROP: if (imem_valid) r_state <= S_REQ;
        default: r_state <= S_REQ;
      endcase
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_valid && stall) begin
            r_buf   <= imem_rdata;
            r_state <= S_HOLD;
          end else if (imem_valid) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= imem_rdata;
            r_ifid_pc4   <= w_pc4;
            r_pc         <= w_pc4;
          end else if (!stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_ifid_valid <= 1'b1;
            r_ifid_instr <= r_buf;
            r_ifid_pc4   <= w_pc4;
            r_pc         <= w_pc4;
            r_state      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_valid) r_state <= S_REQ;
          if (!stall) begin
            r_ifid_valid <= 1'b0;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        w_load_new;
  logic        w_load_bubble;
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  assign w_load_new = !redirect_valid && !stall &&
                      (((r_state == S_REQ) && imem_valid) || (r_state == S_HOLD));
  assign w_load_bubble = redirect_valid || (!stall && !w_load_new);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else begin
      if (w_load_new)    r_perf_fetched <= r_perf_fetched + 32'd1;
      if (w_load_bubble) r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed vectors, one check task, one summary line.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  opcode;
  logic [5:0]  funct;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_before;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4),
    .opcode(opcode),
`ifdef FETCH_PERF_CNT_EN
    .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles),
`endif
    .funct(funct)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then settle 1 time unit past the edge.
  task automatic step(input logic v, input logic [31:0] rd, input logic st,
                      input logic rv, input logic [31:0] rpc);
    imem_valid     = v;
    imem_rdata     = rd;
    stall          = st;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    imem_valid = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #1;
    chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    step(0, 0, 0, 0, 0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_pc4",   ifid_pc4,   32'h0);
    chk("rst_addr",  imem_addr,  32'h0);
    reset_n = 1'b1;
    #1;
    chk("req_after_rst", {31'b0, imem_req}, 32'd1);

    // zero-wait fetches
    step(1, 32'h8C220004, 0, 0, 0);
    chk("f0_valid",  {31'b0, ifid_valid}, 32'd1);
    chk("f0_opcode", {26'b0, opcode}, 32'h23);
    chk("f0_pc4",    ifid_pc4, 32'h4);
    chk("f0_addr",   imem_addr, 32'h4);
    step(1, 32'h00221820, 0, 0, 0);
    chk("f1_opcode", {26'b0, opcode}, 32'h0);
    chk("f1_funct",  {26'b0, funct}, 32'h20);
    chk("f1_pc4",    ifid_pc4, 32'h8);
    chk("f1_addr",   imem_addr, 32'h8);

    // stall for 3 cycles while the word at 0x8 returns
    step(1, 32'h20080005, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req",   {31'b0, imem_req}, 32'd0);
      chk("hold_instr", ifid_instr, 32'h00221820);
      chk("hold_pc4",   ifid_pc4, 32'h8);
      if (i < 2) step(0, 0, 1, 0, 0);
    end
    step(0, 0, 0, 0, 0);
    chk("rel_instr", ifid_instr, 32'h20080005);
    chk("rel_pc4",   ifid_pc4, 32'hC);
    chk("rel_addr",  imem_addr, 32'hC);
    chk("rel_req",   {31'b0, imem_req}, 32'd1);

    // fetch at 0xC, then redirect to 0x40 while the 0x10 request is pending
    step(1, 32'hAC010000, 0, 0, 0);
    chk("f3_addr", imem_addr, 32'h10);
    step(0, 0, 0, 1, 32'h40);
    chk("drop_valid", {31'b0, ifid_valid}, 32'd0);
    chk("drop_instr", ifid_instr, 32'h0);
    chk("drop_addr",  imem_addr, 32'h10);
    chk("drop_req",   {31'b0, imem_req}, 32'd1);
    step(1, 32'hDEADBEEF, 0, 0, 0);
    chk("stale_valid", {31'b0, ifid_valid}, 32'd0);
    chk("stale_instr", ifid_instr, 32'h0);
    chk("tgt_addr",    imem_addr, 32'h40);
    step(0, 0, 0, 0, 0);
    chk("wait_addr",   imem_addr, 32'h40);
    step(1, 32'h08000010, 0, 0, 0);
    chk("tgt_opcode", {26'b0, opcode}, 32'h02);
    chk("tgt_pc4",    ifid_pc4, 32'h44);

    // redirect together with stall, misaligned target, response same cycle
    step(1, 32'h12345678, 1, 1, 32'h103);
    chk("rs_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rs_instr", ifid_instr, 32'h0);
    chk("rs_addr",  imem_addr, 32'h100);

    // reset while in S_DROP
    step(0, 0, 0, 1, 32'h200);
    chk("d2_addr", imem_addr, 32'h100);
    reset_n = 1'b0;
    step(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    #1;
    chk("rd_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rd_addr",  imem_addr, 32'h0);
    chk("rd_req",   {31'b0, imem_req}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk("rd_nostale", {31'b0, ifid_valid}, 32'd0);
    step(1, 32'h8C220004, 0, 0, 0);
    chk("rd_instr", ifid_instr, 32'h8C220004);
    chk("rd_pc4",   ifid_pc4, 32'h4);

    // PC wrap at top of address space
    step(1, 32'hFFFFFFFF, 0, 1, 32'hFFFFFFFC);
    chk("wr_addr", imem_addr, 32'hFFFFFFFC);
`ifdef FETCH_PERF_CNT_EN
    perf_before = perf_fetched;
`endif
    step(1, 32'h03E00008, 0, 0, 0);
    chk("wr_pc4",   ifid_pc4, 32'h0);
    chk("wr_addr2", imem_addr, 32'h0);
    chk("wr_funct", {26'b0, funct}, 32'h08);
`ifdef FETCH_PERF_CNT_EN
    chk("wr_perf", perf_fetched, perf_before + 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
